// File: rtl/i3c_dma_burst_ctrl_pkg.sv
// rtl/i3c_dma_burst_ctrl_pkg.sv - channel state type and beat-size helpers
`include "i3c_params.v"

package i3c_dma_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `I3C_DMA_ST_IDLE,
    ST_REQ  = `I3C_DMA_ST_REQ,
    ST_GAP  = `I3C_DMA_ST_GAP
  } chan_state_e;

  // Reserved encoding behaves as 4-byte beats.
  function automatic logic [2:0] unit_bytes(input logic [1:0] unit_sz);
    case (unit_sz)
      `I3C_DMA_UNIT_1B: return 3'd1;
      `I3C_DMA_UNIT_2B: return 3'd2;
      default:          return 3'd4;
    endcase
  endfunction

  function automatic logic [1:0] unit_shift(input logic [1:0] unit_sz);
    case (unit_sz)
      `I3C_DMA_UNIT_1B: return 2'd0;
      `I3C_DMA_UNIT_2B: return 2'd1;
      default:          return 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/i3c_dma_burst_ctrl_if.sv
// rtl/i3c_dma_burst_ctrl_if.sv - DMA request/ack handshake bundle for both channels

interface i3c_dma_burst_ctrl_if;
  logic       dma_req_fb;
  logic       dma_req_tb;
  logic       dma_req_fb_ack;
  logic       dma_req_tb_ack;
  logic       dma_last_fb;
  logic       dma_last_tb;
  logic [1:0] dma_err;

  modport master (
    output dma_req_fb, dma_req_tb, dma_last_fb, dma_last_tb, dma_err,
    input  dma_req_fb_ack, dma_req_tb_ack
  );

  modport slave (
    input  dma_req_fb, dma_req_tb, dma_last_fb, dma_last_tb, dma_err,
    output dma_req_fb_ack, dma_req_tb_ack
  );
endinterface

// File: rtl/i3c_dma_burst_chan.sv
// rtl/i3c_dma_burst_chan.sv - one DMA channel: threshold check, beat counter, IDLE/REQ/GAP FSM
// Last-beat flop present only when I3C_DMA_LAST_EN is defined.

module i3c_dma_burst_chan
  import i3c_dma_burst_ctrl_pkg::*;
#(
  parameter int LVL_W     = 5,
  parameter int BURST_W   = 3,
  parameter int HAS_FLUSH = 0
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               en,
  input  logic [1:0]         unit_sz,
  input  logic [BURST_W-1:0] blen,
  input  logic [LVL_W-1:0]   level,
  input  logic               flush,
  input  logic               ack,
  output logic               req,
  output logic               last,
  output logic               err
);

  localparam int NW = LVL_W + BURST_W + 2;

  chan_state_e        state, state_n;
  logic [BURST_W-1:0] cnt, cnt_n;
  logic [NW-1:0]      unit_w, need, level_w;
  logic [LVL_W-1:0]   lvl_beats;
  logic [BURST_W-1:0] flush_cnt;
  logic               flush_ok;
  logic               err_set;
  logic               req_q;
  logic               err_q;

  assign unit_w    = NW'(unit_bytes(unit_sz));
  assign level_w   = NW'(level);
  assign need      = (NW'(blen) + NW'(1)) * unit_w;
  // Flush bursts only start when level < need, so level/unit never exceeds blen.
  assign lvl_beats = level >> unit_shift(unit_sz);
  assign flush_cnt = BURST_W'(lvl_beats - LVL_W'(1));
  assign flush_ok  = (HAS_FLUSH != 0) && flush && (level_w < need) && (level_w >= unit_w);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en && level_w >= need) begin
          state_n = ST_REQ;
          cnt_n   = blen;
        end else if (en && flush_ok) begin
          state_n = ST_REQ;
          cnt_n   = flush_cnt;
        end
      end
      ST_REQ: begin
        if (ack) begin
          err_set = (level_w < unit_w);
          if (cnt == '0) state_n = ST_GAP;
          else           cnt_n   = cnt - BURST_W'(1);
        end
      end
      ST_GAP:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    // Disable beats a same-cycle ack.
    if (!en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      err_set = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      req_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      req_q <= (state_n == ST_REQ);
      err_q <= en ? (err_q | err_set) : 1'b0;
    end
  end

  assign req = req_q;
  assign err = err_q;

`ifdef I3C_DMA_LAST_EN
  logic last_q;
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) last_q <= 1'b0;
    else          last_q <= (state_n == ST_REQ) && (cnt_n == '0);
  end
  assign last = last_q;
`else
  assign last = 1'b0;
`endif

endmodule

// File: rtl/i3c_params.v
// rtl/i3c_params.v - shared DMA channel state and beat-size encodings
`ifndef I3C_PARAMS_V
`define I3C_PARAMS_V
`define I3C_DMA_ST_IDLE 2'd0
`define I3C_DMA_ST_REQ 2'd1
`define I3C_DMA_ST_GAP 2'd2
`define I3C_DMA_UNIT_1B 2'd0
`define I3C_DMA_UNIT_2B 2'd1
`define I3C_DMA_UNIT_4B 2'd2
`define I3C_DMA_UNIT_RSVD 2'd3
`endif

// File: rtl/i3c_dma_burst_ctrl.sv
// rtl/i3c_dma_burst_ctrl.sv - RX/TX I3C DMA burst request controller
// Last-beat outputs are driven only when I3C_DMA_LAST_EN is defined.

module i3c_dma_burst_ctrl
  import i3c_dma_burst_ctrl_pkg::*;
#(
  parameter int LVL_W   = 5,
  parameter int BURST_W = 3
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 rx_en,
  input  logic                 tx_en,
  input  logic [1:0]           unit_sz,
  input  logic [BURST_W-1:0]   rx_blen,
  input  logic [BURST_W-1:0]   tx_blen,
  input  logic [LVL_W-1:0]     rx_level,
  input  logic [LVL_W-1:0]     tx_space,
  input  logic                 rx_flush,
  i3c_dma_burst_ctrl_if.master bus
);

  // Holds both channels idle for the first edge after reset release.
  logic run;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) run <= 1'b0;
    else          run <= 1'b1;
  end

  logic rx_err, tx_err;

  i3c_dma_burst_chan #(.LVL_W(LVL_W), .BURST_W(BURST_W), .HAS_FLUSH(1)) u_rx (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .en      (rx_en & run),
    .unit_sz (unit_sz),
    .blen    (rx_blen),
    .level   (rx_level),
    .flush   (rx_flush),
    .ack     (bus.dma_req_fb_ack),
    .req     (bus.dma_req_fb),
    .last    (bus.dma_last_fb),
    .err     (rx_err)
  );

  i3c_dma_burst_chan #(.LVL_W(LVL_W), .BURST_W(BURST_W), .HAS_FLUSH(0)) u_tx (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .en      (tx_en & run),
    .unit_sz (unit_sz),
    .blen    (tx_blen),
    .level   (tx_space),
    .flush   (1'b0),
    .ack     (bus.dma_req_tb_ack),
    .req     (bus.dma_req_tb),
    .last    (bus.dma_last_tb),
    .err     (tx_err)
  );

  assign bus.dma_err = {tx_err, rx_err};

endmodule
